// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the hazard scoreboard.
//   - default stage count, Tnew/Tuse width and MDU latencies
//   - entry_t: one tracked in-flight instruction {valid, dst, tnew}
//   - max2: small elaboration-time helper
package hazard_pkg;

  localparam int NSTAGE_DEF   = 3;
  localparam int TW_DEF       = 2;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // entry_t has a fixed tnew field; any TW up to this width is supported,
  // and narrower Tnew values are stored zero-extended.
  localparam int TNEW_MAX_W   = 4;

  typedef struct packed {
    logic                  valid;
    logic [4:0]            dst;
    logic [TNEW_MAX_W-1:0] tnew;
  } entry_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// mdu_busy_counter: countdown of the remaining multiply/divide busy cycles.
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset, aborts any operation in flight
//   i_start - load the counter this edge (mult/div leaves D)
//   i_div   - 1 selects DIV_LAT, 0 selects MULT_LAT
//   o_busy  - counter is non-zero
module mdu_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy
);

  localparam int CW = $clog2(max2(MULT_LAT, DIV_LAT) + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_start)
      r_cnt <= i_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    else if (r_cnt != '0)
      r_cnt <= r_cnt - CW'(1);
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tnew/Tuse data-hazard tracker for the D stage.
// Tracks the destinations of the NSTAGE instructions after D (entry 1 = E,
// entry NSTAGE = oldest), decides whether D must stall and from which stage
// each D source should be forwarded, and blocks MDU users while the
// multiply/divide unit is busy.
//   clk, reset           - clock, asynchronous active-low reset
//   d_valid              - D holds a real instruction
//   d_rs, d_rt           - D source registers
//   d_tuse_rs, d_tuse_rt - cycles until D needs each source
//   d_dst, d_tnew        - D destination (0 = none) and its result latency
//   d_md_start, d_md_div - D starts a mult (div when d_md_div)
//   d_mdu_use            - D touches the MDU (mult/div/mfhi/mflo/mthi/mtlo)
//   flush                - kill all tracked entries on this edge
//   stall                - hold F/D, bubble into E
//   fwd_rs, fwd_rt       - 0 = register file, k = forward from stage k
//   mdu_busy             - MDU still counting down
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGE   = NSTAGE_DEF,
  parameter int TW       = TW_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         d_valid,
  input  logic [4:0]                   d_rs,
  input  logic [4:0]                   d_rt,
  input  logic [TW-1:0]                d_tuse_rs,
  input  logic [TW-1:0]                d_tuse_rt,
  input  logic [4:0]                   d_dst,
  input  logic [TW-1:0]                d_tnew,
  input  logic                         d_md_start,
  input  logic                         d_md_div,
  input  logic                         d_mdu_use,
  input  logic                         flush,
  output logic                         stall,
  output logic [$clog2(NSTAGE+1)-1:0]  fwd_rs,
  output logic [$clog2(NSTAGE+1)-1:0]  fwd_rt,
  output logic                         mdu_busy
);

  localparam int FW = $clog2(NSTAGE + 1);

  entry_t [NSTAGE:1] r_ent;

  logic          w_conf_rs, w_conf_rt;
  logic [FW-1:0] w_fwd_rs, w_fwd_rt;
  logic          w_busy, w_stall, w_md_load;

  // Walk from oldest to youngest so a younger match overwrites an older one:
  // the lowest-numbered matching entry alone decides conflict and forward.
  always_comb begin
    w_conf_rs = 1'b0;
    w_conf_rt = 1'b0;
    w_fwd_rs  = '0;
    w_fwd_rt  = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (r_ent[k].valid && (r_ent[k].dst == d_rs) && (d_rs != 5'd0)) begin
        w_conf_rs = (r_ent[k].tnew > TNEW_MAX_W'(d_tuse_rs));
        w_fwd_rs  = (r_ent[k].tnew == '0) ? FW'(k) : '0;
      end
      if (r_ent[k].valid && (r_ent[k].dst == d_rt) && (d_rt != 5'd0)) begin
        w_conf_rt = (r_ent[k].tnew > TNEW_MAX_W'(d_tuse_rt));
        w_fwd_rt  = (r_ent[k].tnew == '0) ? FW'(k) : '0;
      end
    end
  end

  assign w_stall   = d_valid & (w_conf_rs | w_conf_rt | (d_mdu_use & w_busy));
  assign w_md_load = d_md_start & d_valid & ~w_stall;

  // Entries advance every cycle regardless of stall; a stall only turns the
  // entry-1 load into a bubble. tnew saturates at 0 as it ages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ent <= '0;
    end else begin
      r_ent[1].valid <= d_valid & ~w_stall & (d_dst != 5'd0) & ~flush;
      r_ent[1].dst   <= d_dst;
      r_ent[1].tnew  <= TNEW_MAX_W'(d_tnew);
      for (int k = 2; k <= NSTAGE; k++) begin
        r_ent[k].valid <= r_ent[k-1].valid & ~flush;
        r_ent[k].dst   <= r_ent[k-1].dst;
        r_ent[k].tnew  <= (r_ent[k-1].tnew == '0) ? '0
                                                  : r_ent[k-1].tnew - TNEW_MAX_W'(1);
      end
    end
  end

  // flush is deliberately not routed here: an MDU operation in flight finishes.
  mdu_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_mdu (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_start (w_md_load),
    .i_div   (d_md_div),
    .o_busy  (w_busy)
  );

  assign stall    = w_stall;
  assign fwd_rs   = w_fwd_rs;
  assign fwd_rt   = w_fwd_rt;
  assign mdu_busy = w_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed hazard scenarios followed by random traffic.
// The reference model keeps a list of issued instructions with the cycle they
// entered E; stage, remaining Tnew and MDU busy time are derived from ages.
module tb_hazard_scoreboard;

  localparam int NSTAGE   = 3;
  localparam int TW       = 2;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic d_valid, d_md_start, d_md_div, d_mdu_use, flush;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic stall, mdu_busy;
  logic [1:0] fwd_rs, fwd_rt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NSTAGE(NSTAGE), .TW(TW), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .reset(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_mdu_use(d_mdu_use),
    .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .mdu_busy(mdu_busy)
  );

  typedef struct { int dst; int tnew0; int issue; } infl_t;
  typedef struct { int stall; int fwd_rs; int fwd_rt; int busy; } exp_t;

  infl_t fl[$];      // youngest first
  exp_t  exp_q[$];
  int cyc = 0;
  int mdu_done = 0;  // MDU busy while cyc < mdu_done
  int n_chk = 0;
  int n_pass = 0;

  function automatic void look(input int s, input int tuse, output int conf, output int fwd);
    conf = 0;
    fwd  = 0;
    if (s == 0) return;
    foreach (fl[i]) begin
      int age, rem;
      age = cyc - fl[i].issue;
      if (age < NSTAGE && fl[i].dst == s) begin
        rem  = (fl[i].tnew0 - age > 0) ? fl[i].tnew0 - age : 0;
        conf = (rem > tuse) ? 1 : 0;
        fwd  = (rem == 0) ? age + 1 : 0;
        return;
      end
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int crs, crt;
    look(int'(d_rs), int'(d_tuse_rs), crs, e.fwd_rs);
    look(int'(d_rt), int'(d_tuse_rt), crt, e.fwd_rt);
    e.busy  = (cyc < mdu_done) ? 1 : 0;
    e.stall = (d_valid && (crs != 0 || crt != 0 || (d_mdu_use && e.busy != 0))) ? 1 : 0;
    return e;
  endfunction

  // One cycle: predict outputs for the inputs now applied, then advance the
  // model across the next rising edge. Called at posedge+1.
  task automatic step(output int st);
    exp_t e;
    if (!rst_n) begin
      fl.delete();
      mdu_done = 0;
    end
    e = predict();
    exp_q.push_back(e);
    st = e.stall;
    @(posedge clk);
    if (rst_n) begin
      if (flush)
        fl.delete();
      else if (d_valid && e.stall == 0 && d_dst != 5'd0)
        fl.push_front('{int'(d_dst), int'(d_tnew), cyc + 1});
      if (d_md_start && d_valid && e.stall == 0)
        mdu_done = cyc + 1 + (d_md_div ? DIV_LAT : MULT_LAT);
      while (fl.size() > 0 && (cyc + 1 - fl[$].issue) >= NSTAGE)
        void'(fl.pop_back());
    end
    cyc++;
    #1;
  endtask

  task automatic set_d(input int v, input int rs, input int rt, input int trs, input int trt,
                       input int dst, input int tn, input int ms, input int md, input int mu);
    d_valid    = (v != 0);
    d_rs       = 5'(rs);
    d_rt       = 5'(rt);
    d_tuse_rs  = TW'(trs);
    d_tuse_rt  = TW'(trt);
    d_dst      = 5'(dst);
    d_tnew     = TW'(tn);
    d_md_start = (ms != 0);
    d_md_div   = (md != 0);
    d_mdu_use  = (mu != 0);
  endtask

  task automatic idle(input int n);
    int st;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step(st);
  endtask

  // Keep the current D instruction in place while the model says it stalls.
  task automatic hold(input int max_cyc);
    int st, n;
    n = 0;
    do begin
      step(st);
      n++;
    end while (st != 0 && n < max_cyc);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall",    (stall    === 1'b1) ? 1 : ((stall    === 1'b0) ? 0 : -1), e.stall);
      chk("fwd_rs",   $isunknown(fwd_rs) ? -1 : int'(fwd_rs), e.fwd_rs);
      chk("fwd_rt",   $isunknown(fwd_rt) ? -1 : int'(fwd_rt), e.fwd_rt);
      chk("mdu_busy", (mdu_busy === 1'b1) ? 1 : ((mdu_busy === 1'b0) ? 0 : -1), e.busy);
    end
  end

  initial begin
    int st;
    rst_n = 1'b0;
    flush = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // Reset held with live-looking D traffic: everything must stay quiet.
    set_d(1, 5, 6, 0, 0, 5, 3, 1, 1, 1);
    step(st);
    step(st);
    rst_n = 1'b1;
    idle(2);

    // load-use: E load dst=5 tnew=2, D add rs=5 tuse=1
    set_d(1, 0, 0, 3, 3, 5, 2, 0, 0, 0); step(st);
    set_d(1, 5, 0, 1, 3, 6, 1, 0, 0, 0); hold(4);
    idle(3);

    // branch: E add dst=8 tnew=1, D beq rt=8 tuse=0
    set_d(1, 0, 0, 3, 3, 8, 1, 0, 0, 0); step(st);
    set_d(1, 0, 8, 3, 0, 0, 0, 0, 0, 0); hold(4);
    idle(3);

    // youngest wins: two writers of r3 with tnew=0
    set_d(1, 0, 0, 3, 3, 3, 0, 0, 0, 0); step(st);
    set_d(1, 0, 0, 3, 3, 3, 0, 0, 0, 0); step(st);
    set_d(1, 3, 0, 0, 0, 0, 0, 0, 0, 0); step(st);
    // older ready, younger not: the younger one must stall D
    set_d(1, 0, 0, 3, 3, 3, 0, 0, 0, 0); step(st);
    set_d(1, 0, 0, 3, 3, 3, 3, 0, 0, 0); step(st);
    set_d(1, 3, 0, 1, 0, 0, 0, 0, 0, 0); hold(4);
    idle(3);

    // register zero is never a hazard
    set_d(1, 0, 0, 3, 3, 0, 2, 0, 0, 0); step(st);
    set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(st);
    idle(2);

    // divide followed by mflo
    set_d(1, 0, 0, 3, 3, 0, 0, 1, 1, 1); step(st);
    set_d(1, 0, 0, 3, 3, 9, 0, 0, 0, 1); hold(20);
    idle(2);

    // flush with a simultaneous issue while a mult is running
    set_d(1, 0, 0, 3, 3, 0, 0, 1, 0, 1); step(st);
    set_d(1, 0, 0, 3, 3, 4, 3, 0, 0, 0); step(st);
    set_d(1, 0, 0, 3, 3, 7, 2, 0, 0, 0); flush = 1'b1; step(st);
    flush = 1'b0;
    set_d(1, 4, 7, 0, 0, 0, 0, 0, 0, 0); step(st);
    idle(6);

    // reset mid-mult: outputs must clear before any clock edge
    set_d(1, 0, 0, 3, 3, 0, 0, 1, 0, 1); step(st);
    idle(1);
    rst_n = 1'b0; step(st);
    set_d(1, 0, 0, 3, 3, 0, 0, 0, 0, 1); step(st);
    rst_n = 1'b1;
    idle(2);

    // random traffic on a small register set to force overlaps
    for (int i = 0; i < 600; i++) begin
      int v, ms, fl_b;
      v    = ($urandom % 4 != 0) ? 1 : 0;
      fl_b = ($urandom % 20 == 0) ? 1 : 0;
      ms   = (v != 0 && fl_b == 0 && $urandom % 12 == 0) ? 1 : 0;
      set_d(v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            ms, $urandom % 2, (ms != 0 || $urandom % 6 == 0) ? 1 : 0);
      flush = fl_b[0];
      rst_n = ($urandom % 150 == 0) ? 1'b0 : 1'b1;
      step(st);
    end
    flush = 1'b0;
    rst_n = 1'b1;
    idle(1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
